rans_dec: RTL and testbench
===========================

# rans_dec

Streaming rANS decoder: inverse of the team's byte-oriented rANS encoder, using the same RESOLUTION/SYMBOL_WIDTH scaling, frequency-table format and L_MIN = 2^RESOLUTION, L_MAX = L_MIN << SYMBOL_WIDTH state bounds. The host loads the symbol table and the encoder's final state, then feeds encoded bytes in reverse emission order. The block returns symbols in reverse encoding order over a valid/ready stream. It sits between the byte DMA reader and the symbol sink.

## Interface
- RESOLUTION, 10, probability scale bits (SCALE = 2^RESOLUTION)
- SYMBOL_WIDTH, 8, symbol and byte width
- COUNT_WIDTH, 16, symbol-count width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- tbl_wr_i  in  1  table-entry write strobe, honoured only when tbl_ready_o=1
- tbl_symb_i  in  SYMBOL_WIDTH  symbol being written
- tbl_freq_i  in  RESOLUTION  symbol frequency
- tbl_cum_i  in  RESOLUTION  cumulative frequency
- tbl_ready_o  out  1  high in IDLE only
- init_i  in  1  start decode, honoured only in IDLE and with tbl_wr_i=0
- init_state_i  in  STATE_WIDTH (RESOLUTION+SYMBOL_WIDTH)  encoder final state
- init_count_i  in  COUNT_WIDTH  number of symbols to decode
- byte_i  in  SYMBOL_WIDTH  encoded byte
- byte_valid_i  in  1 / byte_ready_o  out  1  byte handshake
- symb_o  out  SYMBOL_WIDTH / symb_valid_o  out  1 / symb_ready_i  in  1  symbol handshake
- done_o  out  1  one-cycle pulse when the last symbol is accepted

## Operation
- Tables:
  - freqtable[symb] holds {freq, cum}.
  - slottable[2^RESOLUTION] maps a slot to a symbol.
- A tbl_wr_i write stores {freq, cum}, then enters FILL: writes slottable[(cum+k) mod SCALE] = symb for k = 0..freq-1, one entry per cycle.
  - freq=0: write freqtable only; no FILL cycles.
- FSM states: IDLE, FILL, LOOKUP, FETCH, CALC, EMIT, RENORM.
- IDLE:
  - tbl_wr_i -> FILL.
  - init_i: load x = init_state_i and cnt = init_count_i.
    - cnt=0: pulse done_o, stay IDLE.
    - x < L_MIN: -> RENORM.
    - Otherwise -> LOOKUP.
- LOOKUP: issue slottable read at slot = x[RESOLUTION-1:0].
- FETCH: register symbol s; issue freqtable read at s.
- CALC: x' = freq * (x >> RESOLUTION) + slot - cum.
  - Compute at STATE_WIDTH+1 bits; store the low STATE_WIDTH bits.
  - Register symb_o = s.
  - -> EMIT.
- EMIT:
  - symb_valid_o=1; hold until symb_ready_i.
  - On acceptance, decrement cnt.
    - cnt reaches 0: pulse done_o, -> IDLE.
    - Else x' < L_MIN: -> RENORM.
    - Else -> LOOKUP.
- RENORM:
  - byte_ready_o=1.
  - Each accepted byte: x = (x << SYMBOL_WIDTH) | byte_i, truncated to STATE_WIDTH.
  - Stay until x >= L_MIN; possibly several bytes.
  - Then -> LOOKUP.
- Inconsistent tables (overlapping or sum > SCALE): the decoder must not hang; the symbol output is undefined.

## Timing
- Reset values:
  - State IDLE, x=0, cnt=0.
  - symb_o=0, symb_valid_o=0, byte_ready_o=0, done_o=0.
  - tbl_ready_o=1 from the first cycle after reset release.
- Table write:
  - tbl_ready_o falls the cycle after an accepted write.
  - It stays low freq cycles (FILL), then rises.
- Symbol latency:
  - init_i (x >= L_MIN) to symb_valid_o = 3 cycles (LOOKUP, FETCH, CALC).
  - Symbol acceptance to next symb_valid_o = 3 cycles without renorm, plus 1 cycle per byte with byte_valid_i held high.
- byte_ready_o is combinational from state only, never from byte_valid_i.
- byte_valid_i outside RENORM is ignored.
- symb_o and symb_valid_o are stable while symb_valid_o=1 and symb_ready_i=0.
- done_o is asserted in the same cycle as the final symb_ready_i acceptance.
- rst_i mid-operation aborts immediately. Table RAM contents are not reset and are retained.

## Structure
- Package rans_pkg holds:
  - RESOLUTION and SYMBOL_WIDTH defaults.
  - Derived STATE_WIDTH, SCALE, L_MIN, L_MAX.
  - FSM state enum.
- Encoder and decoder share these constants from the package.
- One sub-module, rans_dec_tables:
  - freqtable and slottable RAMs, both with synchronous read.
  - FILL address counter and its busy flag.
- The top level holds the FSM, the state register, the counter and the arithmetic.

## Test plan
- Table A=0x41 {512,0}, B=0x42 {512,512}. Checks: FILL lasts 512 cycles per write; tbl_ready_o is low for exactly that period.
- Same table, init x=0x400, count 2, bytes 0x7F:
  - Symbol 1: 0x41, x'=512 -> one byte pulled, x=0x2007F.
  - Symbol 2: 0x41, x'=65663; done_o pulses.
- Encoder round trip: random table with sum = 1024, 1000 random symbols through the encoder; feed its final state and reversed bytes -> symbols match in reverse order.
- Back-pressure: symb_ready_i toggled randomly and byte_valid_i gapped -> identical symbol sequence, outputs stable while stalled.
- Double renorm: table with freq=1 symbol at slot 0, x=0x400 -> x'=1, two bytes consumed before the next LOOKUP.
- Reset asserted during RENORM and during FILL -> all outputs return to reset values; init_count_i=0 -> done_o on the next cycle, no symbol emitted.

Source files
------------

// File: rtl/rans_pkg.sv
// Shared rANS constants and decoder FSM encoding, common to the encoder and decoder.
package rans_pkg;

   localparam int unsigned RESOLUTION_DEF   = 10;
   localparam int unsigned SYMBOL_WIDTH_DEF = 8;
   localparam int unsigned COUNT_WIDTH_DEF  = 16;

   localparam int unsigned STATE_WIDTH = RESOLUTION_DEF + SYMBOL_WIDTH_DEF;
   localparam int unsigned SCALE       = 1 << RESOLUTION_DEF;
   localparam int unsigned L_MIN       = SCALE;
   localparam int unsigned L_MAX       = L_MIN << SYMBOL_WIDTH_DEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_LOOKUP,
      ST_FETCH,
      ST_CALC,
      ST_EMIT,
      ST_RENORM
   } dec_state_e;

endpackage

// File: rtl/rans_dec_tables.sv
// Frequency and slot-to-symbol tables with synchronous reads, plus the slot fill sequencer
// that expands one {freq, cum} write into freq slot entries, one per cycle.
module rans_dec_tables
   import rans_pkg::*;
#(
   parameter int unsigned RES = RESOLUTION_DEF,
   parameter int unsigned SW  = SYMBOL_WIDTH_DEF
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           wr_i,
   input  logic [SW-1:0]  wr_symb_i,
   input  logic [RES-1:0] wr_freq_i,
   input  logic [RES-1:0] wr_cum_i,
   output logic           fill_last_o,
   input  logic           slot_rd_i,
   input  logic [RES-1:0] slot_addr_i,
   output logic [SW-1:0]  slot_symb_o,
   input  logic           freq_rd_i,
   input  logic [SW-1:0]  freq_addr_i,
   output logic [RES-1:0] freq_o,
   output logic [RES-1:0] cum_o
);

   localparam int unsigned NSLOT = 1 << RES;
   localparam int unsigned NSYMB = 1 << SW;

   logic [2*RES-1:0] freqtable [NSYMB];
   logic [SW-1:0]    slottable [NSLOT];

   logic [RES-1:0]   fill_addr_q, fill_addr_d;
   logic [RES-1:0]   fill_left_q, fill_left_d;
   logic [SW-1:0]    fill_symb_q, fill_symb_d;
   logic             fill_busy;
   logic [2*RES-1:0] freq_rdata_q;
   logic [SW-1:0]    slot_rdata_q;

   assign fill_busy   = (fill_left_q != '0);
   assign fill_last_o = (fill_left_q == RES'(1));
   assign slot_symb_o = slot_rdata_q;
   assign freq_o      = freq_rdata_q[2*RES-1:RES];
   assign cum_o       = freq_rdata_q[RES-1:0];

   // Slot address wraps naturally at SCALE, giving the (cum+k) mod SCALE placement.
   always_comb begin
      fill_addr_d = fill_addr_q;
      fill_left_d = fill_left_q;
      fill_symb_d = fill_symb_q;
      if (wr_i) begin
         fill_addr_d = wr_cum_i;
         fill_left_d = wr_freq_i;
         fill_symb_d = wr_symb_i;
      end else if (fill_busy) begin
         fill_addr_d = fill_addr_q + RES'(1);
         fill_left_d = fill_left_q - RES'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fill_addr_q <= '0;
         fill_left_q <= '0;
         fill_symb_q <= '0;
      end else begin
         fill_addr_q <= fill_addr_d;
         fill_left_q <= fill_left_d;
         fill_symb_q <= fill_symb_d;
      end
   end

   // RAM contents are deliberately not reset so tables survive an aborting reset.
   always_ff @(posedge clk_i) begin
      if (wr_i)      freqtable[wr_symb_i] <= {wr_freq_i, wr_cum_i};
      if (freq_rd_i) freq_rdata_q <= freqtable[freq_addr_i];
   end

   always_ff @(posedge clk_i) begin
      if (fill_busy) slottable[fill_addr_q] <= fill_symb_q;
      if (slot_rd_i) slot_rdata_q <= slottable[slot_addr_i];
   end

endmodule

// File: rtl/rans_dec.sv
// Streaming rANS decoder: table load, per-symbol state update and byte renormalisation,
// returning symbols in reverse encoding order over a valid/ready stream.
module rans_dec
   import rans_pkg::*;
#(
   parameter int unsigned RESOLUTION   = RESOLUTION_DEF,
   parameter int unsigned SYMBOL_WIDTH = SYMBOL_WIDTH_DEF,
   parameter int unsigned COUNT_WIDTH  = COUNT_WIDTH_DEF
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               tbl_wr_i,
   input  logic [SYMBOL_WIDTH-1:0]            tbl_symb_i,
   input  logic [RESOLUTION-1:0]              tbl_freq_i,
   input  logic [RESOLUTION-1:0]              tbl_cum_i,
   output logic                               tbl_ready_o,
   input  logic                               init_i,
   input  logic [RESOLUTION+SYMBOL_WIDTH-1:0] init_state_i,
   input  logic [COUNT_WIDTH-1:0]             init_count_i,
   input  logic [SYMBOL_WIDTH-1:0]            byte_i,
   input  logic                               byte_valid_i,
   output logic                               byte_ready_o,
   output logic [SYMBOL_WIDTH-1:0]            symb_o,
   output logic                               symb_valid_o,
   input  logic                               symb_ready_i,
   output logic                               done_o
);

   localparam int unsigned XW  = RESOLUTION + SYMBOL_WIDTH;
   localparam int unsigned XW1 = XW + 1;
   localparam logic [XW-1:0] X_LMIN = XW'(1) << RESOLUTION;

   dec_state_e                state_q, state_d;
   logic [XW-1:0]             x_q, x_d;
   logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [SYMBOL_WIDTH-1:0]   s_q, s_d;
   logic [SYMBOL_WIDTH-1:0]   symb_q, symb_d;
   logic                      symb_valid_q, symb_valid_d;
   logic                      byte_ready_q, byte_ready_d;
   logic                      tbl_ready_q, tbl_ready_d;
   logic                      done_q, done_d;
   logic                      done_c;

   logic                      tbl_wr_c;
   logic                      slot_rd_c;
   logic                      freq_rd_c;
   logic                      fill_last;
   logic [SYMBOL_WIDTH-1:0]   slot_symb;
   logic [RESOLUTION-1:0]     freq, cum;
   logic [XW1-1:0]            calc_c;

   rans_dec_tables #(
      .RES (RESOLUTION),
      .SW  (SYMBOL_WIDTH)
   ) u_tables (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_i        (tbl_wr_c),
      .wr_symb_i   (tbl_symb_i),
      .wr_freq_i   (tbl_freq_i),
      .wr_cum_i    (tbl_cum_i),
      .fill_last_o (fill_last),
      .slot_rd_i   (slot_rd_c),
      .slot_addr_i (x_q[RESOLUTION-1:0]),
      .slot_symb_o (slot_symb),
      .freq_rd_i   (freq_rd_c),
      .freq_addr_i (s_q_next_addr()),
      .freq_o      (freq),
      .cum_o       (cum)
   );

   // Frequency read is addressed by the slot lookup result as it arrives in FETCH.
   function automatic logic [SYMBOL_WIDTH-1:0] s_q_next_addr();
      return slot_symb;
   endfunction

   // x' = freq * (x >> RES) + slot - cum, one bit wider so the intermediate cannot overflow.
   assign calc_c = XW1'(freq) * XW1'(x_q >> RESOLUTION)
                 + XW1'(x_q[RESOLUTION-1:0]) - XW1'(cum);

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      cnt_d     = cnt_q;
      s_d       = s_q;
      symb_d    = symb_q;
      done_d    = 1'b0;
      done_c    = 1'b0;
      tbl_wr_c  = 1'b0;
      slot_rd_c = 1'b0;
      freq_rd_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tbl_wr_i) begin
               tbl_wr_c = 1'b1;
               if (tbl_freq_i != '0) state_d = ST_FILL;
            end else if (init_i) begin
               x_d   = init_state_i;
               cnt_d = init_count_i;
               if (init_count_i == '0)      done_d  = 1'b1;
               else if (init_state_i < X_LMIN) state_d = ST_RENORM;
               else                          state_d = ST_LOOKUP;
            end
         end
         ST_FILL: begin
            if (fill_last) state_d = ST_IDLE;
         end
         ST_LOOKUP: begin
            slot_rd_c = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_FETCH: begin
            freq_rd_c = 1'b1;
            s_d       = slot_symb;
            state_d   = ST_CALC;
         end
         ST_CALC: begin
            x_d     = calc_c[XW-1:0];
            symb_d  = s_q;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (symb_ready_i) begin
               cnt_d = cnt_q - COUNT_WIDTH'(1);
               if (cnt_q == COUNT_WIDTH'(1)) begin
                  done_c  = 1'b1;
                  state_d = ST_IDLE;
               end else if (x_q < X_LMIN) begin
                  state_d = ST_RENORM;
               end else begin
                  state_d = ST_LOOKUP;
               end
            end
         end
         ST_RENORM: begin
            if (byte_valid_i) begin
               x_d = {x_q[RESOLUTION-1:0], byte_i};
               if (x_d >= X_LMIN) state_d = ST_LOOKUP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      symb_valid_d = (state_d == ST_EMIT);
      byte_ready_d = (state_d == ST_RENORM);
      tbl_ready_d  = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         cnt_q        <= '0;
         s_q          <= '0;
         symb_q       <= '0;
         symb_valid_q <= 1'b0;
         byte_ready_q <= 1'b0;
         tbl_ready_q  <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         cnt_q        <= cnt_d;
         s_q          <= s_d;
         symb_q       <= symb_d;
         symb_valid_q <= symb_valid_d;
         byte_ready_q <= byte_ready_d;
         tbl_ready_q  <= tbl_ready_d;
         done_q       <= done_d;
      end
   end

   // Final-symbol done tracks the accepting handshake; the zero-count done is registered.
   assign done_o       = done_q | done_c;
   assign symb_o       = symb_q;
   assign symb_valid_o = symb_valid_q;
   assign byte_ready_o = byte_ready_q;
   assign tbl_ready_o  = tbl_ready_q;

endmodule

// File: tb/tb_rans_dec.sv
// Bench for rans_dec: directed table/renorm/reset cases plus a randomized encoder round trip
// checked against a reference rANS encoder written with plain integer arithmetic.
module tb_rans_dec;

   localparam int unsigned RES  = 10;
   localparam int unsigned SW   = 8;
   localparam int unsigned CW   = 16;
   localparam int unsigned XW   = RES + SW;
   localparam int          NMSG = 1000;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          tbl_wr_i = 1'b0;
   logic [SW-1:0] tbl_symb_i = '0;
   logic [RES-1:0] tbl_freq_i = '0;
   logic [RES-1:0] tbl_cum_i = '0;
   logic          tbl_ready_o;
   logic          init_i = 1'b0;
   logic [XW-1:0] init_state_i = '0;
   logic [CW-1:0] init_count_i = '0;
   logic [SW-1:0] byte_i = '0;
   logic          byte_valid_i = 1'b0;
   logic          byte_ready_o;
   logic [SW-1:0] symb_o;
   logic          symb_valid_o;
   logic          symb_ready_i = 1'b0;
   logic          done_o;

   always #5 clk_i = ~clk_i;

   rans_dec dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tbl_wr_i     (tbl_wr_i),
      .tbl_symb_i   (tbl_symb_i),
      .tbl_freq_i   (tbl_freq_i),
      .tbl_cum_i    (tbl_cum_i),
      .tbl_ready_o  (tbl_ready_o),
      .init_i       (init_i),
      .init_state_i (init_state_i),
      .init_count_i (init_count_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .symb_o       (symb_o),
      .symb_valid_o (symb_valid_o),
      .symb_ready_i (symb_ready_i),
      .done_o       (done_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [SW-1:0] exp_q[$];
   logic [SW-1:0] byte_q[$];
   logic [SW-1:0] enc_bytes[$];

   logic [SW-1:0] tsym[16];
   int            mf[16];
   int            mc[16];
   int            msg[NMSG];
   int            k_syms, nb, rem, acc, f, xs, base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_symb_valid"}, 32'(symb_valid_o), 0);
      chk({tag, "_byte_ready"}, 32'(byte_ready_o), 0);
      chk({tag, "_done"},       32'(done_o), 0);
      chk({tag, "_symb"},       32'(symb_o), 0);
      chk({tag, "_tbl_ready"},  32'(tbl_ready_o), 1);
   endtask

   // Write one table entry and measure how long tbl_ready_o stays low.
   task automatic load_entry(input logic [SW-1:0] s, input int fq, input int cm);
      int n = 0;
      tbl_wr_i   = 1'b1;
      tbl_symb_i = s;
      tbl_freq_i = RES'(fq);
      tbl_cum_i  = RES'(cm);
      @(negedge clk_i);
      tbl_wr_i = 1'b0;
      while (!tbl_ready_o && n < 5000) begin
         n++;
         @(negedge clk_i);
      end
      chk("fill_len", 32'(n), 32'(fq));
   endtask

   task automatic start(input int x, input int cnt);
      init_i       = 1'b1;
      init_state_i = XW'(x);
      init_count_i = CW'(cnt);
      @(negedge clk_i);
      init_i = 1'b0;
   endtask

   // Drain n symbols against exp_q, supplying bytes from byte_q on demand.
   task automatic run_decode(input int n, input bit bp, output int nbytes);
      int got = 0, guard = 0, cyc = 0, last_acc = 0, bsince = 0;
      bit stall = 1'b0, accd;
      logic [SW-1:0] held = '0;
      nbytes = 0;
      while (got < n && guard < 60000) begin
         if (stall) begin
            chk("stall_valid", 32'(symb_valid_o), 1);
            chk("stall_symb", 32'(symb_o), 32'(held));
         end
         symb_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_valid_i = (byte_q.size() > 0) && (!bp || $urandom_range(0, 2) != 0);
         byte_i       = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
         #1;
         accd = symb_valid_o && symb_ready_i;
         chk("done", 32'(done_o), 32'(accd && got == n - 1));
         if (accd) begin
            chk("symb", 32'(symb_o), 32'(exp_q[got]));
            if (!bp && got > 0) chk("gap", 32'(cyc - last_acc), 32'(4 + bsince));
            last_acc = cyc;
            bsince   = 0;
            got++;
         end
         if (byte_ready_o && byte_valid_i) begin
            void'(byte_q.pop_front());
            nbytes++;
            bsince++;
         end
         stall = symb_valid_o && !symb_ready_i;
         held  = symb_o;
         @(negedge clk_i);
         cyc++;
         guard++;
      end
      chk("decode_complete", 32'(got), 32'(n));
      symb_ready_i = 1'b0;
      byte_valid_i = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk_i);
      chk_reset_outs("rst");
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_tbl_ready", 32'(tbl_ready_o), 1);

      // Two half-scale symbols
      load_entry(8'h41, 512, 0);
      load_entry(8'h42, 512, 512);

      // x=0x400: sym A, x'=512 -> byte 0x7F -> x=0x2007F -> sym A
      exp_q  = '{8'h41, 8'h41};
      byte_q = '{8'h7F};
      start('h400, 2);
      chk("lat_lookup", 32'(symb_valid_o), 0);
      @(negedge clk_i);
      chk("lat_fetch", 32'(symb_valid_o), 0);
      @(negedge clk_i);
      chk("lat_calc", 32'(symb_valid_o), 0);
      @(negedge clk_i);
      chk("lat_emit", 32'(symb_valid_o), 1);
      run_decode(2, 1'b0, nb);
      chk("ab_bytes", 32'(nb), 1);
      chk("ab_idle", 32'(tbl_ready_o), 1);

      // Reset in RENORM (x below L_MIN, no bytes offered)
      start(5, 3);
      chk("renorm_ready", 32'(byte_ready_o), 1);
      @(negedge clk_i);
      chk("renorm_hold", 32'(byte_ready_o), 1);
      #2 rst_i = 1'b1;
      #1 chk_reset_outs("rst_renorm");
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Reset during FILL
      tbl_wr_i   = 1'b1;
      tbl_symb_i = 8'h43;
      tbl_freq_i = RES'(100);
      tbl_cum_i  = '0;
      @(negedge clk_i);
      tbl_wr_i = 1'b0;
      chk("fill_busy", 32'(tbl_ready_o), 0);
      repeat (3) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1 chk_reset_outs("rst_fill");
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("fill_aborted", 32'(tbl_ready_o), 1);

      // Zero-count init
      start('h400, 0);
      chk("zero_done", 32'(done_o), 1);
      chk("zero_valid", 32'(symb_valid_o), 0);
      @(negedge clk_i);
      chk("zero_done_pulse", 32'(done_o), 0);
      chk("zero_idle", 32'(tbl_ready_o), 1);

      // Double renorm: freq=1 at slot 0, x'=1 needs two bytes
      load_entry(8'h99, 0, 0);
      load_entry(8'h10, 1, 0);
      exp_q  = '{8'h10, 8'h10};
      byte_q = '{8'h04, 8'h00};
      start('h400, 2);
      run_decode(2, 1'b0, nb);
      chk("dbl_bytes", 32'(nb), 2);

      // Random table summing to SCALE
      k_syms = $urandom_range(4, 16);
      base   = $urandom_range(0, 255);
      rem    = 1024 - k_syms;
      acc    = 0;
      for (int k = 0; k < k_syms; k++) begin
         tsym[k] = 8'(base + 37 * k);
         f       = (k == k_syms - 1) ? rem : int'($urandom_range(0, rem / 2));
         rem    -= f;
         mf[k]   = f + 1;
         mc[k]   = acc;
         acc    += mf[k];
      end
      for (int k = 0; k < k_syms; k++) load_entry(tsym[k], mf[k], mc[k]);

      // Reference byte-oriented rANS encoder
      xs = 1024;
      enc_bytes.delete();
      for (int i = 0; i < NMSG; i++) begin
         msg[i] = $urandom_range(0, k_syms - 1);
         while (xs >= 256 * mf[msg[i]]) begin
            enc_bytes.push_back(8'(xs & 255));
            xs = xs >> 8;
         end
         xs = (xs / mf[msg[i]]) * 1024 + (xs % mf[msg[i]]) + mc[msg[i]];
      end

      for (int pass = 0; pass < 2; pass++) begin
         exp_q.delete();
         byte_q.delete();
         for (int i = NMSG - 1; i >= 0; i--) exp_q.push_back(tsym[msg[i]]);
         for (int i = enc_bytes.size() - 1; i >= 0; i--) byte_q.push_back(enc_bytes[i]);
         start(xs, NMSG);
         run_decode(NMSG, pass == 1, nb);
         chk("rt_idle", 32'(tbl_ready_o), 1);
         @(negedge clk_i);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
